// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive controller: FSM encoding and default frame geometry.
package uart_rx_pkg;

    localparam int unsigned CLKS_PER_BIT_DEF = 16;
    localparam int unsigned DATA_BITS_DEF    = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: qualifies the start bit at mid-bit, samples DATA_BITS data bits
// LSB first, then checks the stop bit and reports a good frame or a framing error.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned DATA_BITS    = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 start_edge,
    input  logic                 enable,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;

    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;

    // State and datapath registers; reset discards any frame in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            clk_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next-state and datapath update; rx is only looked at on the defined sample counts.
    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable && start_edge) begin
                    state_d   = ST_START;
                    clk_cnt_d = '0;
                end
            end
            ST_START: begin
                if (clk_cnt_q == CNT_W'(HALF - 1)) begin
                    clk_cnt_d = '0;
                    if (!rx) begin
                        state_d   = ST_DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    shift_d[bit_idx_q] = rx;
                    clk_cnt_d          = '0;
                    if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                    rx_data_d   = shift_q;
                    rx_valid_d  = rx;
                    frame_err_d = ~rx;
                    clk_cnt_d   = '0;
                    state_d     = ST_IDLE;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: a line model drives frames, expected pulses are queued at
// frame start and matched (kind, data, cycle, busy) when the DUT pulses.
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       start_edge;
    logic       enable;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    typedef struct {
        bit         err;
        logic [7:0] data;
        int         at;
    } exp_t;

    exp_t sb[$];
    int   edges       = 0;
    int   vectors     = 0;
    int   miscompares = 0;

    uart_rx_ctrl #(.CLKS_PER_BIT(16), .DATA_BITS(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .start_edge (start_edge),
        .enable     (enable),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edges <= edges + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every output pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rx_valid === 1'b1 || frame_err === 1'b1) begin
            chk("pulse_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("rx_valid", 32'(rx_valid), 32'(!e.err));
                chk("frame_err", 32'(frame_err), 32'(e.err));
                chk("rx_data", 32'(rx_data), 32'(e.data));
                chk("pulse_cycle", 32'(edges), 32'(e.at));
                chk("busy_at_pulse", 32'(busy), 32'd0);
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start_edge = 1'b0;
            enable     = 1'b1;
            rx         = 1'b1;
        end
    endtask

    // Drives ncyc cycles of a frame starting with start_edge at cycle 0; noise adds stray
    // start_edge pulses and an enable dropout while the data bits are being received.
    task automatic drive_frame(input logic [7:0] d, input logic stop, input int ncyc,
                               input bit push, input bit noise);
        logic [9:0] line;
        int         t0;
        exp_t       e;
        line = {stop, d, 1'b0};
        @(negedge clk);
        t0 = edges;
        if (push) begin
            e.err  = !stop;
            e.data = d;
            e.at   = t0 + 153;
            sb.push_back(e);
        end
        for (int n = 0; n < ncyc; n++) begin
            if (n > 0) @(negedge clk);
            start_edge = (n == 0) || (noise && (n == 30 || n == 70 || n == 100));
            enable     = !(noise && n >= 40 && n < 60);
            rx         = (n / 16 < 10) ? line[n / 16] : 1'b1;
        end
    endtask

    task automatic drain(input string tag);
        idle(3);
        for (int i = 0; i < 400 && sb.size() != 0; i++) idle(1);
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        reset      = 1'b0;
        rx         = 1'b1;
        start_edge = 1'b0;
        enable     = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        idle(4);

        // Good frame 0xA5, then hold of rx_data
        drive_frame(8'hA5, 1'b1, 153, 1'b1, 1'b0);
        drain("drain_a5");
        idle(20);
        chk("hold_a5", 32'(rx_data), 32'hA5);

        // False start: rx low 3 cycles then high
        @(negedge clk);
        start_edge = 1'b1;
        rx         = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            start_edge = 1'b0;
            rx         = (n < 3) ? 1'b0 : 1'b1;
            if (n == 1) chk("glitch_busy_c1", 32'(busy), 32'd1);
            if (n == 8) chk("glitch_busy_c8", 32'(busy), 32'd1);
            if (n == 9) chk("glitch_busy_c9", 32'(busy), 32'd0);
        end
        idle(10);
        chk("glitch_hold", 32'(rx_data), 32'hA5);

        // Framing error 0x5A, rx_data updated and held
        drive_frame(8'h5A, 1'b0, 153, 1'b1, 1'b0);
        drain("drain_5a");
        idle(20);
        chk("hold_after_ferr", 32'(rx_data), 32'h5A);

        // Reset at cycle 50 of a frame; nothing may be reported for it
        drive_frame(8'h77, 1'b1, 50, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_rx_data", 32'(rx_data), 32'd0);
        chk("midrst_rx_valid", 32'(rx_valid), 32'd0);
        chk("midrst_frame_err", 32'(frame_err), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        idle(200);
        drive_frame(8'h3C, 1'b1, 153, 1'b1, 1'b0);
        drain("drain_3c");

        // Stray start_edge and enable dropout mid-frame are ignored
        drive_frame(8'hC3, 1'b1, 153, 1'b1, 1'b1);
        drain("drain_c3_noise");

        // start_edge with enable low in IDLE is ignored
        @(negedge clk);
        enable     = 1'b0;
        start_edge = 1'b1;
        rx         = 1'b0;
        for (int n = 1; n < 16; n++) begin
            @(negedge clk);
            start_edge = 1'b0;
            if (n == 1) chk("dis_busy_c1", 32'(busy), 32'd0);
            if (n == 10) chk("dis_busy_c10", 32'(busy), 32'd0);
        end
        idle(200);
        chk("dis_hold", 32'(rx_data), 32'hC3);

        // Back-to-back 0x00 then 0xFF, second start_edge in the cycle busy drops
        drive_frame(8'h00, 1'b1, 153, 1'b1, 1'b0);
        drive_frame(8'hFF, 1'b1, 153, 1'b1, 1'b0);
        drain("drain_b2b");
        chk("b2b_last", 32'(rx_data), 32'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clock cycles per UART bit period; even, >= 4.
REQ-002 Parameter DATA_BITS, default 8, data bits per frame; range 5..8.
REQ-003 clk  input  1  single system clock; all logic updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 rx  input  1  serial line, already synchronised to clk; idle high.
REQ-006 start_edge  input  1  one-cycle falling-edge indication from the existing rx falling-edge detector.
REQ-007 enable  input  1  permits frame acceptance; sampled only in IDLE.
REQ-008 rx_data  output  DATA_BITS  last received byte, LSB first on the line, registered.
REQ-009 rx_valid  output  1  one-cycle pulse: rx_data updated with a good frame.
REQ-010 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 busy  output  1  high whenever state is not IDLE; decoded from the state register.

Function
REQ-012 The FSM SHALL have the states IDLE, START, DATA and STOP, with internal clk_cnt of width clog2(CLKS_PER_BIT), bit_idx of width clog2(DATA_BITS) and a shift register.
REQ-013 IDLE transitions:
- enable=1 and start_edge=1 -> START, clk_cnt=0.
- Otherwise remain in IDLE.
REQ-014 START behaviour, with H = CLKS_PER_BIT/2:
- While clk_cnt < H-1: increment clk_cnt.
- At clk_cnt = H-1 with rx=0: go to DATA, clk_cnt=0, bit_idx=0.
- At clk_cnt = H-1 with rx=1: false start; return to IDLE with no output pulse.
REQ-015 DATA behaviour:
- At clk_cnt = CLKS_PER_BIT-1: store rx into shift[bit_idx] and set clk_cnt=0.
- If bit_idx = DATA_BITS-1: go to STOP; else increment bit_idx.
- Otherwise increment clk_cnt.
REQ-016 STOP behaviour, at clk_cnt = CLKS_PER_BIT-1:
- rx_data <= shift.
- rx=1: rx_valid <= 1.
- rx=0: frame_err <= 1.
- Go to IDLE.
REQ-017 rx_valid and frame_err SHALL be high for exactly one cycle and never simultaneously.
REQ-018 Latency: with start_edge high in cycle 0, the output pulse SHALL be visible in cycle H + (DATA_BITS+1)*CLKS_PER_BIT + 1, and busy SHALL be low in that same cycle.
REQ-019 start_edge SHALL be ignored outside IDLE, and enable SHALL be ignored outside IDLE; a frame in progress always completes.
REQ-020 A start_edge in the cycle the FSM re-enters IDLE SHALL be accepted, which supports back-to-back frames.
REQ-021 rx_data SHALL hold its value between frames, including after a framing error.
REQ-022 The FSM SHALL NOT re-check rx mid-bit outside the defined sample points, and SHALL NOT abort on line glitches during DATA or STOP.

Reset
REQ-023 On reset=0 at a clock edge, the following SHALL be set regardless of state, including mid-frame:
- State = IDLE.
- clk_cnt = 0, bit_idx = 0, shift = 0.
- rx_data = 0, rx_valid = 0, frame_err = 0, busy = 0.
REQ-024 A frame that is interrupted by reset SHALL be discarded without any output pulse.

Structure
REQ-025 The state encoding (IDLE, START, DATA, STOP) and the default CLKS_PER_BIT/DATA_BITS constants SHALL live in shared package uart_rx_pkg.
REQ-026 No sub-module is required.
REQ-027 The falling-edge detector SHALL be instantiated alongside this block in the parent, not inside it.

Verification (CLKS_PER_BIT=16, DATA_BITS=8, H=8; cycle 0 = start_edge cycle; nominal pulse cycle 153)
REQ-028 Frame 0xA5 with stop=1 -> rx_valid=1 for one cycle at cycle 153, rx_data=0xA5, frame_err=0, busy low at cycle 153.
REQ-029 rx low for 3 cycles then high (glitch) -> FSM returns to IDLE at cycle 9, and no rx_valid or frame_err occurs.
REQ-030 Frame 0x5A with stop=0 -> frame_err pulse at cycle 153, rx_valid stays 0, rx_data=0x5A.
REQ-031 reset=0 at cycle 50 of a frame -> all outputs 0 and busy=0 on the next cycle; a subsequent frame 0x3C is received correctly.
REQ-032 Extra start_edge pulses during DATA, and start_edge with enable=0 in IDLE -> both are ignored with no spurious frame.
REQ-033 Back-to-back frames 0x00 then 0xFF, with the second start_edge in the cycle busy drops -> two rx_valid pulses, the second 153 cycles after the first.
